// File: rtl/vga_fb_scanout.sv
// VGA 640x480@60 scanout from a 320x240, 3-bit frame buffer with 2x
// pixel/line replication. Three tick-aligned stages: counters and decode,
// frame-buffer fetch, registered RGB and sync outputs.
module vga_fb_scanout #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int FB_W     = 320
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        pix_en,
    input  logic        enable,
    output logic        rd_en,
    output logic [16:0] rd_addr,
    input  logic [2:0]  rd_data,
    output logic        vga_r,
    output logic        vga_g,
    output logic        vga_b,
    output logic        hsync_n,
    output logic        vsync_n,
    output logic        frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    logic [HW-1:0] hcount;
    logic [VW-1:0] vcount;
    logic          frame_en;
    logic          h_last, v_last, origin, active, hs_act, vs_act;
    logic          fe_now, fetch;
    logic [16:0]   fb_x, fb_y, addr_calc;
    logic          s1_fetch, s1_hs, s1_vs;
    logic [2:0]    rgb;

    // Stage-0 decode of the current scan position
    always_comb begin
        h_last = (int'(hcount) == H_TOTAL - 1);
        v_last = (int'(vcount) == V_TOTAL - 1);
        origin = (hcount == '0) && (vcount == '0);
        active = (int'(hcount) < H_ACTIVE) && (int'(vcount) < V_ACTIVE);
        hs_act = (int'(hcount) >= H_ACTIVE + H_FP) &&
                 (int'(hcount) <  H_ACTIVE + H_FP + H_SYNC);
        vs_act = (int'(vcount) >= V_ACTIVE + V_FP) &&
                 (int'(vcount) <  V_ACTIVE + V_FP + V_SYNC);
        // The enable sampled at the origin tick must already govern the
        // origin pixel itself, otherwise pixel (0,0) would use the old frame's
        // setting and the frame would be partially drawn.
        fe_now = origin ? enable : frame_en;
        fetch  = active && fe_now;
        fb_x   = 17'(hcount >> 1);
        fb_y   = 17'(vcount >> 1);
    end

    // Row-pitch multiply; the 320 case is a two-term shift-add (256 + 64)
    generate
        if (FB_W == 320) begin : g_pitch320
            assign addr_calc = (fb_y << 8) + (fb_y << 6) + fb_x;
        end else begin : g_pitch_gen
            assign addr_calc = fb_y * 17'(FB_W) + fb_x;
        end
    endgenerate

    // Horizontal/vertical position counters, advanced only on ticks
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hcount <= '0;
            vcount <= '0;
        end else if (pix_en) begin
            if (h_last) begin
                hcount <= '0;
                vcount <= v_last ? '0 : vcount + VW'(1);
            end else begin
                hcount <= hcount + HW'(1);
            end
        end
    end

    // Display enable latched only at the frame origin
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            frame_en <= 1'b0;
        else if (pix_en && origin)
            frame_en <= enable;
    end

    // Stage 1: fetch strobe (one clock wide), address, and pipelined flags
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_en    <= 1'b0;
            rd_addr  <= '0;
            s1_fetch <= 1'b0;
            s1_hs    <= 1'b0;
            s1_vs    <= 1'b0;
        end else begin
            rd_en <= 1'b0;
            if (pix_en) begin
                rd_en    <= fetch;
                s1_fetch <= fetch;
                s1_hs    <= hs_act;
                s1_vs    <= vs_act;
                if (fetch)
                    rd_addr <= addr_calc;
            end
        end
    end

    // Stage 2: colour and syncs registered together so they stay aligned
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rgb     <= 3'b000;
            hsync_n <= 1'b1;
            vsync_n <= 1'b1;
        end else if (pix_en) begin
            rgb     <= s1_fetch ? rd_data : 3'b000;
            hsync_n <= ~s1_hs;
            vsync_n <= ~s1_vs;
        end
    end

    assign {vga_r, vga_g, vga_b} = rgb;
    // Gated by reset so the pulse cannot appear while held in reset at (0,0)
    assign frame_start = reset_n & pix_en & origin;

endmodule
